// File: rtl/mux_rr_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter family.
package mux_rr_arb_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_SEL_WIDTH = 2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage : mux_rr_arb_pkg

// File: rtl/mux_rr_pick.sv
// Combinational rotating-priority picker: the first requester after last_i
// (with wrap) wins, so last_i itself has the lowest priority.
module mux_rr_pick #(
  parameter  int SEL_WIDTH  = 2,
  localparam int NUM_INPUTS = 1 << SEL_WIDTH
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [SEL_WIDTH-1:0]  last_i,
  output logic                  any_o,
  output logic [SEL_WIDTH-1:0]  winner_o
);

  logic [SEL_WIDTH-1:0] idx;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = '0;
    // Scan from the farthest offset down so the nearest request writes last.
    for (int i = NUM_INPUTS; i >= 1; i--) begin
      idx = last_i + SEL_WIDTH'(i);
      if (req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule : mux_rr_pick

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding one registered N-to-1 mux stage (valid/ready).
// Optional grant locking is compiled in with `define MUX_RR_ARB_LOCK_EN.
module mux_rr_arbiter
  import mux_rr_arb_pkg::*;
#(
  parameter  int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter  int SEL_WIDTH  = DEF_SEL_WIDTH,
  localparam int NUM_INPUTS = 1 << SEL_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_INPUTS-1:0] i_valid,
  input  logic [BIT_WIDTH-1:0]  i_data [0:NUM_INPUTS-1],
  output logic [NUM_INPUTS-1:0] o_ready,
  output logic                  o_valid,
  output logic [BIT_WIDTH-1:0]  o_data,
  output logic [SEL_WIDTH-1:0]  o_sel,
  input  logic                  i_ready
`ifdef MUX_RR_ARB_LOCK_EN
  ,
  input  logic                  i_lock
`endif
);

  logic                  o_valid_q;
  logic [BIT_WIDTH-1:0]  o_data_q;
  logic [SEL_WIDTH-1:0]  o_sel_q;
  logic [SEL_WIDTH-1:0]  last_q;

  logic [NUM_INPUTS-1:0] req;
  logic                  any_req;
  logic [SEL_WIDTH-1:0]  winner;
  logic                  pipe_free;
  logic                  grant;

  assign pipe_free = !o_valid_q || i_ready;

`ifdef MUX_RR_ARB_LOCK_EN
  lock_state_e          state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_idx_q, lock_idx_d;

  // While locked, only the locked requester is visible to the picker.
  assign req = (state_q == LOCKED) ? (i_valid & (NUM_INPUTS'(1) << lock_idx_q))
                                   : i_valid;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      UNLOCKED: if (grant && i_lock) begin
        state_d    = LOCKED;
        lock_idx_d = winner;
      end
      LOCKED:   if (grant && !i_lock) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign req = i_valid;
`endif

  mux_rr_pick #(
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .any_o    (any_req),
    .winner_o (winner)
  );

  // Gated by reset so no requester sees an accept while the stage is held clear.
  assign grant   = i_rst_n && pipe_free && any_req;
  assign o_ready = grant ? (NUM_INPUTS'(1) << winner) : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sel_q   <= '0;
      last_q    <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else if (grant) begin
      o_valid_q <= 1'b1;
      o_data_q  <= i_data[winner];
      o_sel_q   <= winner;
      last_q    <= winner;
    end else if (i_ready) begin
      o_valid_q <= 1'b0;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sel   = o_sel_q;

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, hand sequences and
// randomized traffic against a behavioural model (lock tests with MUX_RR_ARB_LOCK_EN).
module tb_mux_rr_arbiter;

  localparam int BW = 16;
  localparam int SW = 2;
  localparam int N  = 1 << SW;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_valid;
  logic [BW-1:0] i_data [0:N-1];
  logic [N-1:0]  o_ready;
  logic          o_valid;
  logic [BW-1:0] o_data;
  logic [SW-1:0] o_sel;
  logic          i_ready;
`ifdef MUX_RR_ARB_LOCK_EN
  logic          i_lock;
`endif

  mux_rr_arbiter #(.BIT_WIDTH(BW), .SEL_WIDTH(SW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .i_ready (i_ready)
`ifdef MUX_RR_ARB_LOCK_EN
    ,
    .i_lock  (i_lock)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arbitration described as a modular scan from last+1.
  logic          m_valid;
  logic [BW-1:0] m_data;
  int            m_sel, m_last, m_lidx;
  logic          m_locked;

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_sel    = 0;
    m_last   = N - 1;
    m_locked = 1'b0;
    m_lidx   = 0;
  endtask

  // One clock: drive inputs, compare o_ready, advance the model, compare outputs.
  task automatic cycle(input logic [N-1:0] v, input logic r, input logic lk,
                       output logic [N-1:0] seen_rdy);
    int win;
    logic [N-1:0] exp_rdy;
    i_valid = v;
    i_ready = r;
`ifdef MUX_RR_ARB_LOCK_EN
    i_lock  = lk;
`endif
    #1;
    win = -1;
    if (!m_valid || r) begin
      if (m_locked) begin
        if (v[m_lidx]) win = m_lidx;
      end else begin
        for (int j = 1; j <= N; j++) begin
          int k;
          k = (m_last + j) % N;
          if (win < 0 && v[k]) win = k;
        end
      end
    end
    exp_rdy  = (win >= 0) ? N'(1 << win) : '0;
    seen_rdy = o_ready;
    check("model_o_ready", o_ready, exp_rdy);
    @(posedge i_clk);
    #1;
    if (win >= 0) begin
      m_valid = 1'b1;
      m_data  = i_data[win];
      m_sel   = win;
      m_last  = win;
      if (!m_locked && lk) begin
        m_locked = 1'b1;
        m_lidx   = win;
      end else if (m_locked && !lk) begin
        m_locked = 1'b0;
      end
    end else if (r) begin
      m_valid = 1'b0;
    end
    check("model_o_valid", o_valid, m_valid);
    check("model_o_sel", o_sel, m_sel);
    check("model_o_data", o_data, m_data);
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic          ready;
    logic [N-1:0]  exp_rdy;
    logic          exp_valid;
    logic [SW-1:0] exp_sel;
    logic [BW-1:0] exp_data;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [N-1:0] rdy;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00A0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h00A1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00A3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00A0};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    tbl[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00A0};
    tbl[7]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h00A1};
    tbl[8]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00A3};
    tbl[9]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00A3};
    tbl[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd3, 16'h00A3};
    tbl[11] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd3, 16'h00A3};
    tbl[12] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd3, 16'h00A3};
    tbl[13] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h00A1};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 16'h00A1};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 16'h00A1};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 16'h00A1};
    tbl[17] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    tbl[18] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h00A2};

    i_rst_n = 1'b0;
    i_valid = '0;
    i_ready = 1'b0;
`ifdef MUX_RR_ARB_LOCK_EN
    i_lock  = 1'b0;
`endif
    for (int k = 0; k < N; k++) i_data[k] = 16'h00A0 + 16'(k);
    model_reset();

    // Reset state, with all requesters asking.
    #3;
    i_valid = 4'b1111;
    #1;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_data", o_data, 16'h0000);
    check("rst_o_sel", o_sel, 2'd0);
    check("rst_o_ready", o_ready, 4'b0000);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Rotation, sparse/wrap, backpressure and drain vectors.
    for (int t = 0; t < 19; t++) begin
      cycle(tbl[t].valid, tbl[t].ready, 1'b0, rdy);
      check($sformatf("tbl%0d_o_ready", t), rdy, tbl[t].exp_rdy);
      check($sformatf("tbl%0d_o_valid", t), o_valid, tbl[t].exp_valid);
      check($sformatf("tbl%0d_o_sel", t), o_sel, tbl[t].exp_sel);
      check($sformatf("tbl%0d_o_data", t), o_data, tbl[t].exp_data);
    end

    // Asynchronous reset while the output stage holds a word.
    i_valid = 4'b1111;
    i_ready = 1'b0;
    i_rst_n = 1'b0;
    #2;
    check("midrst_o_valid", o_valid, 1'b0);
    check("midrst_o_data", o_data, 16'h0000);
    check("midrst_o_sel", o_sel, 2'd0);
    check("midrst_o_ready", o_ready, 4'b0000);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle(4'b1111, 1'b1, 1'b0, rdy);
    check("postrst_first_grant", rdy, 4'b0001);
    check("postrst_o_sel", o_sel, 2'd0);

`ifdef MUX_RR_ARB_LOCK_EN
    cycle(4'b1111, 1'b1, 1'b0, rdy);
    check("lock_pre_grant1", rdy, 4'b0010);
    cycle(4'b1111, 1'b1, 1'b1, rdy);
    check("lock_take2", rdy, 4'b0100);
    cycle(4'b1111, 1'b1, 1'b1, rdy);
    check("lock_hold2_a", rdy, 4'b0100);
    check("lock_hold2_sel", o_sel, 2'd2);
    cycle(4'b1111, 1'b1, 1'b1, rdy);
    check("lock_hold2_b", rdy, 4'b0100);
    cycle(4'b1011, 1'b1, 1'b1, rdy);
    check("lock_stall", rdy, 4'b0000);
    check("lock_stall_valid", o_valid, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0, rdy);
    check("lock_release2", rdy, 4'b0100);
    cycle(4'b1111, 1'b1, 1'b0, rdy);
    check("unlock_next3", rdy, 4'b1000);
    check("unlock_next3_sel", o_sel, 2'd3);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      logic lk;
      for (int k = 0; k < N; k++) i_data[k] = BW'($urandom);
      lk = 1'b0;
`ifdef MUX_RR_ARB_LOCK_EN
      lk = ($urandom_range(0, 3) == 0);
`endif
      cycle(N'($urandom), ($urandom_range(0, 3) != 0), lk, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mux_rr_arbiter

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one registered N-to-1 data mux among NUM_INPUTS valid/ready requesters and presents the winner on a single valid/ready output stage. It sits between parallel producers (e.g. neuron-lane result buffers) and a single consumer (output buffer or writeback port) in the accelerator datapath. Fairness is rotating priority with one-cycle latency and full throughput.

## Interface
- BIT_WIDTH, 16, data width per requester
- SEL_WIDTH, 2, select width; NUM_INPUTS = 1 << SEL_WIDTH (derived, not overridable)
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  NUM_INPUTS  per-requester request/valid, bit k = requester k
- i_data  input  BIT_WIDTH x NUM_INPUTS (unpacked array [0:NUM_INPUTS-1])  per-requester data
- o_ready  output  NUM_INPUTS  per-requester accept, at most one bit high
- o_valid  output  1  output stage holds data
- o_data  output  BIT_WIDTH  registered winner data
- o_sel  output  SEL_WIDTH  index of requester whose data is in o_data
- i_ready  input  1  consumer accept
- i_lock  input  1  lock request (present only with MUX_RR_ARB_LOCK_EN)

## Operation
- Reset values: o_valid=0, o_data=0, o_sel=0, o_ready=0, last-grant pointer=NUM_INPUTS-1 (requester 0 highest priority first), lock state UNLOCKED.
- pipe_free = !o_valid || i_ready.
- When pipe_free and any i_valid: winner = first k with i_valid[k] scanning (last+1) mod NUM_INPUTS upward with wrap; o_ready[winner]=1 combinationally, all others 0.
- Transfer from requester k occurs when i_valid[k] && o_ready[k]; at that edge o_data<=i_data[k], o_sel<=k, o_valid<=1, last<=k.
- When pipe_free and no i_valid: o_ready=0; if i_ready, o_valid<=0 at edge (o_data, o_sel hold).
- When !pipe_free: o_ready=0, output stage holds (o_data stable while o_valid && !i_ready).
- Requester must hold i_valid/i_data until accepted; arbiter does not require it but a dropped request simply loses its turn.
- Pointer moves only on transfer; a requester that wins is lowest priority next cycle.

## Timing
- Latency: request accepted in cycle t appears on o_valid/o_data at t+1.
- Throughput: one transfer per cycle while i_ready=1.
- o_ready depends combinationally on i_valid, i_ready, pointer; no combinational path from i_data to any output.
- Simultaneous drain and fill (o_valid && i_ready && transfer): new data replaces old at the same edge, o_valid stays 1.
- Reset asserted mid-transfer: all outputs clear immediately (asynchronous); any in-flight output word is discarded.

## Configuration
- MUX_RR_ARB_LOCK_EN defined: i_lock port exists; two-state FSM UNLOCKED/LOCKED with locked index L.
  - UNLOCKED -> LOCKED (L<=k) on transfer from k with i_lock=1.
  - LOCKED: only requester L may win; others see o_ready=0 even if pipe_free; no grant if i_valid[L]=0 (stall).
  - LOCKED -> UNLOCKED on transfer from L with i_lock=0; pointer<=L.
  - Reset returns to UNLOCKED.
- Undefined: no i_lock port, no FSM, pure round robin.

## Structure
- Package mux_rr_arb_pkg: lock-state enum (UNLOCKED, LOCKED), default BIT_WIDTH/SEL_WIDTH constants.
- Sub-module mux_rr_pick: combinational rotating-priority picker (inputs: request vector, last pointer; outputs: any, winner index); reused by future arbiters.
- Top holds pointer, output register, lock FSM.

## Test plan
- Reset: drive i_rst_n=0 mid-run with o_valid=1 -> o_valid=0, o_data=0, o_sel=0 immediately; after release first grant to requester 0 when i_valid=4'b1111.
- Rotation: i_valid=4'b1111, i_data[k]=16'h00A0+k, i_ready=1 -> o_sel sequence 0,1,2,3,0 on consecutive cycles, o_data 00A0..00A3,00A0.
- Sparse/wrap: last=2, i_valid=4'b0011 -> grant 0 then 1; i_valid=4'b1000 after last=3 -> grant 3 again.
- Backpressure: o_valid=1, i_ready=0 for 3 cycles with i_valid=4'b0110 -> o_ready=0, o_data/o_sel stable; i_ready=1 -> grant 1 next edge, no data lost.
- Empty drain: single transfer then i_valid=0, i_ready=1 -> o_valid falls one cycle after the word is consumed.
- Lock (macro defined): transfer from 2 with i_lock=1, all i_valid=1 -> o_sel=2 repeatedly; i_valid[2]=0 -> stall with o_ready=0; transfer from 2 with i_lock=0 -> next grant 3.
